// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-high {g,f,e,d,c,b,a} hex glyphs,
// digit-strobe encodings and the types used by the capture decoder.
package seg7_pkg;

   localparam logic [6:0] SEG_PAT_0 = 7'h3F;
   localparam logic [6:0] SEG_PAT_1 = 7'h06;
   localparam logic [6:0] SEG_PAT_2 = 7'h5B;
   localparam logic [6:0] SEG_PAT_3 = 7'h4F;
   localparam logic [6:0] SEG_PAT_4 = 7'h66;
   localparam logic [6:0] SEG_PAT_5 = 7'h6D;
   localparam logic [6:0] SEG_PAT_6 = 7'h7D;
   localparam logic [6:0] SEG_PAT_7 = 7'h07;
   localparam logic [6:0] SEG_PAT_8 = 7'h7F;
   localparam logic [6:0] SEG_PAT_9 = 7'h6F;
   localparam logic [6:0] SEG_PAT_A = 7'h77;
   localparam logic [6:0] SEG_PAT_B = 7'h7C;
   localparam logic [6:0] SEG_PAT_C = 7'h39;
   localparam logic [6:0] SEG_PAT_D = 7'h5E;
   localparam logic [6:0] SEG_PAT_E = 7'h79;
   localparam logic [6:0] SEG_PAT_F = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   localparam logic [3:0] CODE_ERR = 4'hF;
   localparam logic [1:0] DIG_TENS = 2'b10;
   localparam logic [1:0] DIG_ONES = 2'b01;

   typedef enum logic {ST_EMPTY, ST_FULL} out_state_e;

   typedef struct packed {
      logic       err;
      logic [3:0] code;
   } digit_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational reverse lookup of an active-high segment pattern to its hex
// code; anything outside the 16 glyphs (blank included) flags an error.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg_pat,
   output digit_t     digit
);

   always_comb begin
      digit.err  = 1'b0;
      digit.code = CODE_ERR;
      case (seg_pat)
         SEG_PAT_0: digit.code = 4'h0;
         SEG_PAT_1: digit.code = 4'h1;
         SEG_PAT_2: digit.code = 4'h2;
         SEG_PAT_3: digit.code = 4'h3;
         SEG_PAT_4: digit.code = 4'h4;
         SEG_PAT_5: digit.code = 4'h5;
         SEG_PAT_6: digit.code = 4'h6;
         SEG_PAT_7: digit.code = 4'h7;
         SEG_PAT_8: digit.code = 4'h8;
         SEG_PAT_9: digit.code = 4'h9;
         SEG_PAT_A: digit.code = 4'hA;
         SEG_PAT_B: digit.code = 4'hB;
         SEG_PAT_C: digit.code = 4'hC;
         SEG_PAT_D: digit.code = 4'hD;
         SEG_PAT_E: digit.code = 4'hE;
         SEG_PAT_F: digit.code = 4'hF;
         default:   digit.err  = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Samples a 2-digit multiplexed seven-segment bus, debounces each digit and
// emits decoded {tens,ones} frames over a valid/ready handshake.
module seg7_capture_decoder
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] seg_in,
   input  logic [1:0] dig_sel,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [3:0] tens_code,
   output logic [3:0] ones_code,
   output logic       tens_err,
   output logic       ones_err,
   output logic       overflow
);

   localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

   logic [8:0] sample;
   logic [8:0] prev_sample;
   logic [7:0] stab_cnt, stab_cnt_nxt;
   logic       armed, armed_nxt;
   logic       sample_changed, capture, cap_tens, cap_ones;
   logic [6:0] seg_norm;
   digit_t     dec, tens_slot, ones_slot, tens_slot_nxt, ones_slot_nxt;
   logic       tens_flag, ones_flag, tens_flag_nxt, ones_flag_nxt;
   logic       frame_done, load, drop;
   out_state_e state, state_nxt;

   assign sample   = {dig_sel, seg_in};
   assign seg_norm = SEG_ACTIVE_LOW ? ~seg_in : seg_in;

   seg7_pattern_decode u_decode (
      .seg_pat (seg_norm),
      .digit   (dec)
   );

   always_comb begin
      sample_changed = (sample != prev_sample);
      if (sample_changed)
         stab_cnt_nxt = 8'd1;
      else if (stab_cnt < STABLE_MAX)
         stab_cnt_nxt = stab_cnt + 8'd1;
      else
         stab_cnt_nxt = stab_cnt;

      // A new sample re-arms; arming is consumed by the single capture per stable period
      armed_nxt = sample_changed | armed;
      capture   = armed_nxt && (stab_cnt_nxt == STABLE_MAX);
      cap_tens  = capture && (dig_sel == DIG_TENS);
      cap_ones  = capture && (dig_sel == DIG_ONES);
      if (cap_tens || cap_ones)
         armed_nxt = 1'b0;

      tens_slot_nxt = cap_tens ? dec : tens_slot;
      ones_slot_nxt = cap_ones ? dec : ones_slot;
      tens_flag_nxt = tens_flag | cap_tens;
      ones_flag_nxt = ones_flag | cap_ones;

      frame_done = tens_flag_nxt & ones_flag_nxt;
      load       = frame_done && ((state == ST_EMPTY) || out_ready);
      drop       = frame_done && !load;

      state_nxt = state;
      case (state)
         ST_EMPTY: if (load) state_nxt = ST_FULL;
         ST_FULL:  if (out_ready && !load) state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_EMPTY;
         prev_sample <= '0;
         stab_cnt    <= '0;
         armed       <= 1'b0;
         tens_flag   <= 1'b0;
         ones_flag   <= 1'b0;
         tens_code   <= 4'h0;
         ones_code   <= 4'h0;
         tens_err    <= 1'b0;
         ones_err    <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         state       <= state_nxt;
         prev_sample <= sample;
         stab_cnt    <= stab_cnt_nxt;
         armed       <= armed_nxt;
         tens_flag   <= frame_done ? 1'b0 : tens_flag_nxt;
         ones_flag   <= frame_done ? 1'b0 : ones_flag_nxt;
         if (load) begin
            tens_code <= tens_slot_nxt.code;
            ones_code <= ones_slot_nxt.code;
            tens_err  <= tens_slot_nxt.err;
            ones_err  <= ones_slot_nxt.err;
         end
         if (drop)
            overflow <= 1'b1;
      end
   end

   // Slot contents are only meaningful alongside their flags, so they need no reset
   always_ff @(posedge clk) begin
      tens_slot <= tens_slot_nxt;
      ones_slot <= ones_slot_nxt;
   end

   assign out_valid = (state == ST_FULL);

endmodule
